// File: rtl/ps2_mouse_grid_rx.sv
// ============================================================================
// Module   : ps2_mouse_grid_rx
// Brief    : PS/2 mouse receiver that decodes 3-byte packets into a grid cell cursor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_mouse_grid_rx #(
    parameter int CELLS_X     = 128,
    parameter int CELLS_Y     = 96,
    parameter int CELL_TICKS  = 10,
    parameter int HYSTERESIS  = 2,
    parameter int WRAP        = 0,
    parameter int INVERT_Y    = 1,
    parameter int TIMEOUT_CYC = 50000,
    parameter int ACC_W       = 12,
    localparam int X_W        = $clog2(CELLS_X),
    localparam int Y_W        = $clog2(CELLS_Y)
) (
    input  logic           CLOCK_50,
    input  logic           reset,
    input  logic           ps2_clk_i,
    input  logic           ps2_dat_i,
    input  logic           home,
    output logic           button_left,
    output logic           button_right,
    output logic           button_middle,
    output logic [X_W-1:0] cell_x,
    output logic [Y_W-1:0] cell_y,
    output logic           pkt_valid,
    output logic           frame_err
);

    localparam int TCNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam int TH     = CELL_TICKS + HYSTERESIS;

    localparam logic signed [ACC_W-1:0] TH_S    = TH[ACC_W-1:0];
    localparam logic signed [ACC_W-1:0] NTH_S   = -TH_S;
    localparam logic signed [ACC_W-1:0] CT_S    = CELL_TICKS[ACC_W-1:0];
    localparam logic signed [ACC_W:0]   SAT_P   = (ACC_W+1)'((1 << (ACC_W - 1)) - 1);
    localparam logic signed [ACC_W:0]   SAT_N   = -SAT_P;
    localparam logic [X_W-1:0]          X_MAX   = X_W'(CELLS_X - 1);
    localparam logic [Y_W-1:0]          Y_MAX   = Y_W'(CELLS_Y - 1);
    localparam logic [TCNT_W-1:0]       TCNT_TO = TCNT_W'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_CHECK = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic                     clk_s0_q, clk_s1_q, dat_s0_q, dat_s1_q;
    logic [3:0]               bitcnt_q, bitcnt_d;
    logic [9:0]               shreg_q, shreg_d;
    logic [TCNT_W-1:0]        tcnt_q, tcnt_d;
    logic [1:0]               idx_q, idx_d;
    logic [6:0]               hdr_q, hdr_d;
    logic [7:0]               dx_q, dx_d;
    logic [2:0]               btn_q, btn_d;
    logic signed [ACC_W-1:0]  acc_x_q, acc_x_d, acc_y_q, acc_y_d;
    logic [X_W-1:0]           cell_x_q, cell_x_d;
    logic [Y_W-1:0]           cell_y_q, cell_y_d;
    logic                     pkt_q, err_q;

    logic                     w_fall, w_byte_ok, w_frame_bad, w_latch;
    logic signed [ACC_W:0]    w_dx_ext, w_dy_raw, w_dy_ext;

    function automatic logic signed [ACC_W-1:0] sat_add(
        input logic signed [ACC_W-1:0] acc,
        input logic signed [ACC_W:0]   delta
    );
        logic signed [ACC_W:0] s;
        s = {acc[ACC_W-1], acc} + delta;
        if (s > SAT_P) s = SAT_P;
        else if (s < SAT_N) s = SAT_N;
        return s[ACC_W-1:0];
    endfunction

    assign w_fall = clk_s1_q & ~clk_s0_q;

    // Receive FSM: frame shift, timeout and parity/stop validation
    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        shreg_d     = shreg_q;
        tcnt_d      = tcnt_q;
        w_byte_ok   = 1'b0;
        w_frame_bad = 1'b0;
        case (state_q)
            S_IDLE: begin
                tcnt_d = '0;
                if (w_fall && !dat_s1_q) begin
                    state_d  = S_SHIFT;
                    bitcnt_d = 4'd0;
                end
            end
            S_SHIFT: begin
                if (w_fall) begin
                    shreg_d  = {dat_s1_q, shreg_q[9:1]};
                    bitcnt_d = bitcnt_q + 4'd1;
                    tcnt_d   = '0;
                    if (bitcnt_q == 4'd9) state_d = S_CHECK;
                end else if (tcnt_q == TCNT_TO) begin
                    w_frame_bad = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                end
            end
            S_CHECK: begin
                state_d = S_IDLE;
                if ((^shreg_q[8:0]) && shreg_q[9]) w_byte_ok   = 1'b1;
                else                               w_frame_bad = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign w_latch  = w_byte_ok && (idx_q == 2'd2);
    assign w_dx_ext = hdr_q[5] ? '0 : {{(ACC_W-8){hdr_q[3]}}, hdr_q[3], dx_q};
    assign w_dy_raw = {{(ACC_W-8){hdr_q[4]}}, hdr_q[4], shreg_q[7:0]};
    assign w_dy_ext = hdr_q[6] ? '0 : ((INVERT_Y != 0) ? -w_dy_raw : w_dy_raw);

    // Packet assembly, accumulators and cursor stepping
    always_comb begin
        idx_d    = idx_q;
        hdr_d    = hdr_q;
        dx_d     = dx_q;
        btn_d    = btn_q;
        acc_x_d  = acc_x_q;
        acc_y_d  = acc_y_q;
        cell_x_d = cell_x_q;
        cell_y_d = cell_y_q;

        if (w_frame_bad) begin
            idx_d = 2'd0;
        end else if (w_byte_ok) begin
            case (idx_q)
                2'd0: begin
                    // Header bit3 is always set; anything else is a misaligned byte
                    if (shreg_q[3]) begin
                        hdr_d = {shreg_q[7:4], shreg_q[2:0]};
                        idx_d = 2'd1;
                    end
                end
                2'd1: begin
                    dx_d  = shreg_q[7:0];
                    idx_d = 2'd2;
                end
                default: idx_d = 2'd0;
            endcase
        end

        if (w_latch) btn_d = hdr_q[2:0];

        if (home) begin
            acc_x_d  = '0;
            acc_y_d  = '0;
            cell_x_d = '0;
            cell_y_d = '0;
        end else if (w_latch) begin
            acc_x_d = sat_add(acc_x_q, w_dx_ext);
            acc_y_d = sat_add(acc_y_q, w_dy_ext);
        end else begin
            if (acc_x_q >= TH_S) begin
                acc_x_d  = acc_x_q - CT_S;
                cell_x_d = (cell_x_q == X_MAX) ? ((WRAP != 0) ? '0 : X_MAX) : cell_x_q + X_W'(1);
            end else if (acc_x_q <= NTH_S) begin
                acc_x_d  = acc_x_q + CT_S;
                cell_x_d = (cell_x_q == '0) ? ((WRAP != 0) ? X_MAX : '0) : cell_x_q - X_W'(1);
            end
            if (acc_y_q >= TH_S) begin
                acc_y_d  = acc_y_q - CT_S;
                cell_y_d = (cell_y_q == Y_MAX) ? ((WRAP != 0) ? '0 : Y_MAX) : cell_y_q + Y_W'(1);
            end else if (acc_y_q <= NTH_S) begin
                acc_y_d  = acc_y_q + CT_S;
                cell_y_d = (cell_y_q == '0) ? ((WRAP != 0) ? Y_MAX : '0) : cell_y_q - Y_W'(1);
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            clk_s0_q <= 1'b1;
            clk_s1_q <= 1'b1;
            dat_s0_q <= 1'b1;
            dat_s1_q <= 1'b1;
            state_q  <= S_IDLE;
            bitcnt_q <= 4'd0;
            shreg_q  <= '0;
            tcnt_q   <= '0;
            idx_q    <= 2'd0;
            hdr_q    <= '0;
            dx_q     <= '0;
            btn_q    <= '0;
            acc_x_q  <= '0;
            acc_y_q  <= '0;
            cell_x_q <= '0;
            cell_y_q <= '0;
            pkt_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            clk_s0_q <= ps2_clk_i;
            clk_s1_q <= clk_s0_q;
            dat_s0_q <= ps2_dat_i;
            dat_s1_q <= dat_s0_q;
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
            tcnt_q   <= tcnt_d;
            idx_q    <= idx_d;
            hdr_q    <= hdr_d;
            dx_q     <= dx_d;
            btn_q    <= btn_d;
            acc_x_q  <= acc_x_d;
            acc_y_q  <= acc_y_d;
            cell_x_q <= cell_x_d;
            cell_y_q <= cell_y_d;
            pkt_q    <= w_latch;
            err_q    <= w_frame_bad;
        end
    end

    assign button_left   = btn_q[0];
    assign button_right  = btn_q[1];
    assign button_middle = btn_q[2];
    assign cell_x        = cell_x_q;
    assign cell_y        = cell_y_q;
    assign pkt_valid     = pkt_q;
    assign frame_err     = err_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_mouse_grid_rx.sv
// ============================================================================
// Module   : tb_ps2_mouse_grid_rx
// Brief    : Directed bench for ps2_mouse_grid_rx with a button scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ps2_mouse_grid_rx;

    localparam int TO_CYC = 400;
    localparam int HALF   = 8;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b0;
    logic       ps2_clk  = 1'b1;
    logic       ps2_dat  = 1'b1;
    logic       home     = 1'b0;
    logic       bl, br, bm, pv, fe;
    logic [6:0] cx, cy;
    logic       w_bl, w_br, w_bm, w_pv, w_fe;
    logic [6:0] w_cx, w_cy;

    int         compared = 0;
    int         mism     = 0;
    int         pkt_seen = 0;
    int         pkt_exp  = 0;
    int         err_seen = 0;
    int         err_exp  = 0;
    logic [2:0] exp_q[$];
    bit         got;
    logic [6:0] x0, x1;

    always #10 CLOCK_50 = ~CLOCK_50;

    ps2_mouse_grid_rx #(.TIMEOUT_CYC(TO_CYC)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .ps2_clk_i(ps2_clk), .ps2_dat_i(ps2_dat),
        .home(home), .button_left(bl), .button_right(br), .button_middle(bm),
        .cell_x(cx), .cell_y(cy), .pkt_valid(pv), .frame_err(fe)
    );

    ps2_mouse_grid_rx #(.TIMEOUT_CYC(TO_CYC), .WRAP(1)) dut_wrap (
        .CLOCK_50(CLOCK_50), .reset(reset), .ps2_clk_i(ps2_clk), .ps2_dat_i(ps2_dat),
        .home(home), .button_left(w_bl), .button_right(w_br), .button_middle(w_bm),
        .cell_x(w_cx), .cell_y(w_cy), .pkt_valid(w_pv), .frame_err(w_fe)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every accepted packet must match the oldest expected button set
    always @(negedge CLOCK_50) begin
        if (pv === 1'b1) begin
            pkt_seen++;
            if (exp_q.size() == 0) check("pkt_unexpected", 32'd1, 32'd0);
            else check("pkt_buttons", {29'd0, bm, br, bl}, {29'd0, exp_q.pop_front()});
        end
        if (fe === 1'b1) err_seen++;
    end

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge CLOCK_50) ps2_dat = f[i];
            repeat (HALF) @(negedge CLOCK_50);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge CLOCK_50);
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
        repeat (2 * HALF) @(negedge CLOCK_50);
    endtask

    task automatic wait_pkt(input int bound);
        got = 1'b0;
        for (int i = 0; i < bound && !got; i++) begin
            @(negedge CLOCK_50);
            if (pv === 1'b1) got = 1'b1;
        end
        x0 = cx;
        @(negedge CLOCK_50);
        x1 = cx;
    endtask

    task automatic wait_err(input int bound);
        got = 1'b0;
        for (int i = 0; i < bound && !got; i++) begin
            @(negedge CLOCK_50);
            if (fe === 1'b1) got = 1'b1;
        end
    endtask

    task automatic packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input string tag);
        exp_q.push_back(b0[2:0]);
        pkt_exp++;
        fork
            begin
                send_frame(b0, 1'b0, 11);
                send_frame(b1, 1'b0, 11);
                send_frame(b2, 1'b0, 11);
            end
            wait_pkt(3000);
        join
        check(tag, {31'd0, got}, 32'd1);
        repeat (12) @(negedge CLOCK_50);
    endtask

    task automatic pulse_home();
        @(negedge CLOCK_50) home = 1'b1;
        @(negedge CLOCK_50) home = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge CLOCK_50);
        check("rst_outputs", {25'd0, bl, br, bm, pv, fe, 2'd0}, 32'd0);
        check("rst_cells", {18'd0, cx, cy}, 32'd0);
        reset = 1'b1;
        repeat (4) @(negedge CLOCK_50);

        // Basic packet: +12 in X, left button
        packet(8'h09, 8'h0C, 8'h00, "pkt1_seen");
        check("pkt1_x_at_pulse", x0, 7'd0);
        check("pkt1_x_after", x1, 7'd1);
        check("pkt1_left", bl, 1'b1);
        check("pkt1_y", cy, 7'd0);

        // Reset in the middle of a frame
        send_frame(8'h09, 1'b0, 5);
        @(negedge CLOCK_50) reset = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        check("midrst_outputs", {27'd0, bl, br, bm, pv, fe}, 32'd0);
        check("midrst_cells", {18'd0, cx, cy}, 32'd0);
        reset = 1'b1;
        repeat (4) @(negedge CLOCK_50);
        packet(8'h08, 8'h0C, 8'h00, "pkt2_seen");
        check("pkt2_x", cx, 7'd1);
        check("pkt2_left", bl, 1'b0);

        pulse_home();
        check("home1_cells", {18'd0, cx, cy}, 32'd0);

        // dy = -12 inverted -> down one row
        packet(8'h28, 8'h00, 8'hF4, "pkt3_seen");
        check("pkt3_y", cy, 7'd1);
        check("pkt3_x", cx, 7'd0);

        // dx = -12 at column 0: clamp vs wrap
        packet(8'h18, 8'hF4, 8'h00, "pkt4_seen");
        check("clamp_x", cx, 7'd0);
        check("wrap_x", w_cx, 7'd127);
        check("pkt4_y", cy, 7'd1);

        // +14 after the clamped step: residue -2 + 14 = 12 -> one step
        packet(8'h08, 8'h0E, 8'h00, "pkt5_seen");
        check("nowindup_x", cx, 7'd1);
        check("wrap_back_x", w_cx, 7'd0);

        // Corrupted parity on byte1, then a good packet
        send_frame(8'h09, 1'b0, 11);
        send_frame(8'h0C, 1'b1, 11);
        err_exp++;
        check("par_err_count", err_seen, err_exp);
        check("par_no_pkt", pkt_seen, pkt_exp);
        packet(8'h09, 8'h0C, 8'h00, "pkt6_seen");
        check("pkt6_x", cx, 7'd2);
        check("pkt6_left", bl, 1'b1);

        // Stray non-header byte is dropped silently
        send_frame(8'h04, 1'b0, 11);
        packet(8'h08, 8'h0C, 8'h00, "pkt7_seen");
        check("resync_no_err", err_seen, err_exp);
        check("pkt7_x", cx, 7'd3);
        check("pkt7_wrap_x", w_cx, 7'd2);

        // Timeout after 5 bits
        send_frame(8'h08, 1'b0, 5);
        wait_err(TO_CYC + 100);
        err_exp++;
        check("timeout_err", {31'd0, got}, 32'd1);
        repeat (4) @(negedge CLOCK_50);
        check("timeout_err_count", err_seen, err_exp);
        packet(8'h0A, 8'h00, 8'h00, "pkt8_seen");
        check("pkt8_right", {30'd0, br, bl}, 32'd2);
        check("pkt8_cells", {18'd0, cx, cy}, {18'd0, 7'd3, 7'd1});

        pulse_home();
        check("home2_cells", {18'd0, cx, cy}, 32'd0);
        check("home2_wrap_cells", {18'd0, w_cx, w_cy}, 32'd0);

        repeat (4) @(negedge CLOCK_50);
        check("sb_pkt_count", pkt_seen, pkt_exp);
        check("sb_queue_empty", exp_q.size(), 32'd0);
        check("err_total", err_seen, err_exp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end

endmodule

`default_nettype wire
